jtframe_sdram_arb: RTL and testbench
====================================

Name: jtframe_sdram_arb

Overview:
- Shares the single game-side SDRAM read port (sdram_req/sdram_addr/sdram_ack/data_read/data_rdy) among N ROM clients, e.g. main CPU, sound CPU, char, scroll and object fetchers.
- Keeps one cached word per client, so repeated reads of the same address return without an SDRAM access.
- Schedules misses round-robin.
- Drives refresh_en, and gates all access during ROM download and loop reset.
- Sits inside the game top, between the per-game fetch logic and the jtframe SDRAM controller.

Parameters:
- N, 4, number of clients (2..8).
- AW, 22, SDRAM word address width.
- DW, 32, read data width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- downloading  in  1  ROM download in progress.
- loop_rst  in  1  synchronous abort/flush request from the frame.
- client_cs  in  N  per-client read request, level.
- client_addr  in  N*AW  per-client address; slice i = [i*AW +: AW].
- client_dout  out  N*DW  per-client cached data; slice i.
- client_ok  out  N  per-client data valid for the current address.
- sdram_req  out  1  request to the SDRAM controller.
- sdram_addr  out  AW  request address.
- sdram_ack  in  1  one-cycle pulse: request accepted.
- data_read  in  DW  SDRAM read data.
- data_rdy  in  1  one-cycle pulse: data_read valid.
- refresh_en  out  1  SDRAM refresh permitted.

Behaviour:
- Reset values (async, rst_n=0):
  - sdram_req=0, sdram_addr=0.
  - All cache valid bits=0, cache addr/data=0, so client_ok=0 and client_dout=0.
  - state=IDLE, rr_last=N-1.
- Per-client cache slot i: valid, tag[AW], data[DW].
  - hit[i] = valid[i] & tag[i]==client_addr[i].
  - client_ok[i] = client_cs[i] & hit[i], combinational (zero-latency on hit).
  - client_dout[i] = data[i].
- miss[i] = client_cs[i] & ~hit[i].
- FSM states: IDLE, WAIT_ACK, WAIT_DATA.
  - IDLE:
    - If |miss & ~downloading & ~loop_rst: grant = first set miss in order rr_last+1 … N-1, 0 … rr_last.
    - Latch gnt_idx and gnt_addr=client_addr[grant]; sdram_addr<=gnt_addr; sdram_req<=1; rr_last<=grant; go to WAIT_ACK.
    - The request issues one cycle after the miss is seen.
  - WAIT_ACK:
    - sdram_req held at 1 until sdram_ack.
    - On sdram_ack: sdram_req<=0; go to WAIT_DATA.
    - If sdram_ack and data_rdy arrive in the same cycle, complete directly (fill the cache, go to IDLE).
  - WAIT_DATA:
    - On data_rdy: tag[gnt_idx]<=gnt_addr, data[gnt_idx]<=data_read, valid[gnt_idx]<=1; go to IDLE.
    - client_ok rises the cycle after data_rdy if the client address is unchanged.
- Address changed mid-transaction: the fill still uses the latched gnt_addr. The client then misses again and is re-requested normally. No corruption.
- client_cs dropped mid-transaction: the transaction completes and the cache is filled anyway.
- Miss-to-ok minimum latency: 1 (req) + controller ack + data latency + 1.
- refresh_en = (state==IDLE) & ~|miss. Also forced to 1 while downloading.
- downloading=1:
  - All valid bits are cleared every cycle.
  - No new grants.
  - An in-flight transaction runs to completion, but its data is discarded (valid stays 0).
- loop_rst=1 (synchronous, overrides everything except rst_n):
  - All valid bits cleared; sdram_req<=0; state<=IDLE; rr_last unchanged.
  - A stray data_rdy later in IDLE is ignored.
- data_rdy or sdram_ack in IDLE: ignored.
- Fairness: with every client missing continuously, grants rotate 0,1,…,N-1,0. No client waits more than N-1 transactions.

Decomposition:
- Package jtframe_sdram_arb_pkg holds:
  - the state enum (IDLE, WAIT_ACK, WAIT_DATA);
  - the index width function clog2(N).
- One sub-module, jtframe_rr_pick:
  - combinational round-robin picker;
  - inputs: N-bit req vector and last index;
  - outputs: grant index and any.
- Cache slots stay as generate loops in the top.

Test Plan:
- Single miss: client0 cs=1, addr=0x00100; controller acks after 2 cycles and sends data_rdy 4 cycles later with 0xDEADBEEF → exactly one sdram_req with sdram_addr=0x00100; client_ok[0]=1 with dout=0xDEADBEEF the cycle after data_rdy. A repeat read of 0x00100 gives ok with no new sdram_req.
- Round-robin: all 4 clients miss together, distinct addresses, controller latency fixed → grant order 0,1,2,3; each client_ok rises in that order; exactly 4 SDRAM requests.
- Address change mid-flight: client1 addr 0x00200 → 0x00204 during WAIT_DATA → the cache fills tag 0x00200, ok stays 0, then a second request to 0x00204 follows.
- Download: hit established, then downloading pulsed → ok drops within 1 cycle, no sdram_req while high, refresh_en=1; after release the same address re-fetches.
- loop_rst in WAIT_ACK: sdram_req=1 when loop_rst asserts → next cycle sdram_req=0, state IDLE, all ok=0; a subsequent stray data_rdy does not set any ok.
- Async reset: rst_n low mid-transaction → sdram_req, client_ok and refresh_en-related state return to reset values immediately, without a clock edge.

Source files
------------

// File: rtl/jtframe_sdram_arb_pkg.sv
// jtframe_sdram_arb_pkg: shared types and helpers for the SDRAM ROM arbiter
package jtframe_sdram_arb_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DATA} state_t;
  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return w;
  endfunction
endpackage

// File: rtl/jtframe_sdram_arb_if.sv
// jtframe_sdram_arb_if: game-side SDRAM read port
//   sdram_req/sdram_addr: request from arbiter, sdram_ack: request accepted pulse
//   data_read/data_rdy: read data and its one-cycle valid pulse
interface jtframe_sdram_arb_if #(parameter int AW = 22, parameter int DW = 32);
  logic          sdram_req;
  logic [AW-1:0] sdram_addr;
  logic          sdram_ack;
  logic [DW-1:0] data_read;
  logic          data_rdy;
  modport master(output sdram_req, sdram_addr, input sdram_ack, data_read, data_rdy);
  modport slave(input sdram_req, sdram_addr, output sdram_ack, data_read, data_rdy);
endinterface

// File: rtl/jtframe_sdram_arb_rr_pick.sv
// jtframe_rr_pick: combinational round-robin picker
//   req: request vector, last: previous grant, gnt: next grant, any: some request set
module jtframe_rr_pick
  import jtframe_sdram_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] gnt,
  output logic          any
);
  logic [IW-1:0] j;
  // scanning from farthest to nearest leaves the nearest set request after last
  always_comb begin
    gnt = last;
    j = last;
    for (int k = N; k >= 1; k--) begin
      j = IW'((int'(last) + k) % N);
      if (req[j]) gnt = j;
    end
  end
  assign any = |req;
endmodule

// File: rtl/jtframe_sdram_arb.sv
// jtframe_sdram_arb: shares one SDRAM read port among N cached ROM clients
//   client_cs/client_addr: per-client level requests, client_dout/client_ok: cached word and hit
//   downloading/loop_rst: flush and block grants, refresh_en: SDRAM refresh allowed
//   sdram: read port towards the SDRAM controller
module jtframe_sdram_arb
  import jtframe_sdram_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int AW = 22,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            downloading,
  input  logic            loop_rst,
  input  logic [N-1:0]    client_cs,
  input  logic [N*AW-1:0] client_addr,
  output logic [N*DW-1:0] client_dout,
  output logic [N-1:0]    client_ok,
  output logic            refresh_en,
  jtframe_sdram_arb_if.master sdram
);
  localparam int IW = clog2(N);
  state_t state, state_nx;
  logic [IW-1:0] gnt_idx, rr_last, pick;
  logic [AW-1:0] gnt_addr;
  logic [N-1:0]  hit, miss;
  logic          any, grant, fill;
  assign miss      = client_cs & ~hit;
  assign client_ok = client_cs & hit;
  jtframe_rr_pick #(.N(N), .IW(IW)) u_pick (.req(miss), .last(rr_last), .gnt(pick), .any(any));
  assign grant = state == IDLE && any && !downloading && !loop_rst;
  // ack and data may land together, so WAIT_ACK can complete directly
  assign fill = !loop_rst && sdram.data_rdy &&
                (state == WAIT_DATA || (state == WAIT_ACK && sdram.sdram_ack));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = loop_rst ? IDLE :
               grant    ? WAIT_ACK :
               fill     ? IDLE :
               (state == WAIT_ACK && sdram.sdram_ack) ? WAIT_DATA : state;
  end
  always_comb begin
    sdram.sdram_req  = state == WAIT_ACK;
    sdram.sdram_addr = gnt_addr;
    refresh_en       = downloading || (state == IDLE && !(|miss));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      gnt_idx  <= '0;
      gnt_addr <= '0;
      rr_last  <= IW'(N - 1);
    end else if (grant) begin
      gnt_idx  <= pick;
      gnt_addr <= client_addr[int'(pick)*AW +: AW];
      rr_last  <= pick;
    end
  for (genvar i = 0; i < N; i++) begin : g_slot
    logic          valid;
    logic [AW-1:0] tag;
    logic [DW-1:0] data;
    logic          mine;
    assign mine = fill && gnt_idx == IW'(i);
    // fills during download still land but valid stays low, discarding them
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        valid <= 1'b0;
        tag   <= '0;
        data  <= '0;
      end else begin
        if (mine) begin
          tag  <= gnt_addr;
          data <= sdram.data_read;
        end
        valid <= (loop_rst || downloading) ? 1'b0 : mine ? 1'b1 : valid;
      end
    assign hit[i] = valid && tag == client_addr[i*AW +: AW];
    assign client_dout[i*DW +: DW] = data;
  end
endmodule

// File: tb/tb_jtframe_sdram_arb.sv
// tb_jtframe_sdram_arb: directed self-checking bench for the SDRAM ROM arbiter
module tb_jtframe_sdram_arb;
  localparam int N = 4, AW = 22, DW = 32;
  logic clk = 0, rst_n = 0, downloading = 0, loop_rst = 0;
  logic [N-1:0]    client_cs = '0;
  logic [N*AW-1:0] client_addr = '0;
  logic [N*DW-1:0] client_dout;
  logic [N-1:0]    client_ok;
  logic            refresh_en;
  int n_checks = 0, n_fail = 0;
  jtframe_sdram_arb_if #(.AW(AW), .DW(DW)) sd ();
  jtframe_sdram_arb #(.N(N), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .downloading(downloading), .loop_rst(loop_rst),
    .client_cs(client_cs), .client_addr(client_addr), .client_dout(client_dout),
    .client_ok(client_ok), .refresh_en(refresh_en), .sdram(sd.master)
  );
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] fdata(input logic [AW-1:0] a);
    return 32'hDEADBEEF ^ {10'd0, a ^ 22'h100};
  endfunction

  int cyc = 0, nreq = 0, nrdy = 0, rdy_cyc = -1;
  logic [AW-1:0] req_log[$];
  logic prev_req = 0;
  always @(negedge clk) begin
    cyc++;
    if (sd.sdram_req && !prev_req) begin
      nreq++;
      req_log.push_back(sd.sdram_addr);
    end
    prev_req = sd.sdram_req;
    if (sd.data_rdy) begin
      nrdy++;
      rdy_cyc = cyc;
    end
  end

  int ack_dly = 2, rdy_dly = 4;
  bit rsp_en = 1;
  logic [AW-1:0] rsp_addr;
  initial begin
    sd.sdram_ack = 0;
    sd.data_rdy = 0;
    sd.data_read = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rsp_en && rst_n && sd.sdram_req) begin
        rsp_addr = sd.sdram_addr;
        repeat (ack_dly) @(posedge clk);
        #1 sd.sdram_ack = 1;
        @(posedge clk);
        #1 sd.sdram_ack = 0;
        repeat (rdy_dly - 1) @(posedge clk);
        #1 sd.data_rdy = 1;
        sd.data_read = fdata(rsp_addr);
        @(posedge clk);
        #1 sd.data_rdy = 0;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ok(input int i, input int budget, output bit got);
    got = 0;
    for (int c = 0; c < budget; c++) begin
      step();
      if (client_ok[i]) begin
        got = 1;
        break;
      end
    end
  endtask

  task automatic reset_dut();
    client_cs = '0;
    downloading = 0;
    loop_rst = 0;
    rst_n = 0;
    step();
    step();
    rst_n = 1;
    step();
  endtask

  task automatic test_reset();
    step();
    n_checks++; if (sd.sdram_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", sd.sdram_req); end
    n_checks++; if (sd.sdram_addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", sd.sdram_addr); end
    n_checks++; if (client_dout !== '0) begin n_fail++; $display("FAIL reset_dout: got %h want 0", client_dout); end
    n_checks++; if (refresh_en !== 1'b1) begin n_fail++; $display("FAIL reset_refresh: got %b want 1", refresh_en); end
    client_addr = '0;
    client_cs = 4'hF;
    #1;
    n_checks++; if (client_ok !== 4'h0) begin n_fail++; $display("FAIL reset_ok: got %b want 0000", client_ok); end
    client_cs = '0;
    rst_n = 1;
    step();
    step();
    n_checks++; if (sd.sdram_req !== 1'b0) begin n_fail++; $display("FAIL reset_idle_req: got %b want 0", sd.sdram_req); end
  endtask

  task automatic test_single_miss();
    int n0;
    bit got;
    n0 = nreq;
    client_addr[0 +: AW] = 22'h00100;
    client_cs = 4'b0001;
    wait_ok(0, 40, got);
    n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL single_ok: got %b want 1", got); end
    n_checks++; if (cyc - rdy_cyc !== 1) begin n_fail++; $display("FAIL single_latency: got %0d want 1", cyc - rdy_cyc); end
    n_checks++; if (client_dout[0 +: DW] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_dout: got %h want deadbeef", client_dout[0 +: DW]); end
    n_checks++; if (nreq - n0 !== 1) begin n_fail++; $display("FAIL single_nreq: got %0d want 1", nreq - n0); end
    n_checks++; if (req_log[n0] !== 22'h00100) begin n_fail++; $display("FAIL single_addr: got %h want 00100", req_log[n0]); end
    client_cs = 4'b0000;
    step();
    client_cs = 4'b0001;
    #1;
    n_checks++; if (client_ok[0] !== 1'b1) begin n_fail++; $display("FAIL hit_repeat: got %b want 1", client_ok[0]); end
    repeat (5) step();
    n_checks++; if (nreq - n0 !== 1) begin n_fail++; $display("FAIL hit_no_req: got %0d want 1", nreq - n0); end
    n_checks++; if (refresh_en !== 1'b1) begin n_fail++; $display("FAIL hit_refresh: got %b want 1", refresh_en); end
  endtask

  task automatic test_round_robin();
    int n0;
    int rise[N];
    logic [AW-1:0] a[N];
    bit done;
    reset_dut();
    n0 = nreq;
    a = '{22'h1000, 22'h2000, 22'h3000, 22'h4000};
    for (int i = 0; i < N; i++) begin
      client_addr[i*AW +: AW] = a[i];
      rise[i] = -1;
    end
    client_cs = 4'hF;
    step();
    n_checks++; if (refresh_en !== 1'b0) begin n_fail++; $display("FAIL rr_refresh: got %b want 0", refresh_en); end
    for (int c = 0; c < 200; c++) begin
      done = 1;
      for (int i = 0; i < N; i++) begin
        if (client_ok[i] && rise[i] < 0) rise[i] = cyc;
        if (rise[i] < 0) done = 0;
      end
      if (done) break;
      step();
    end
    step();
    n_checks++; if (nreq - n0 !== 4) begin n_fail++; $display("FAIL rr_nreq: got %0d want 4", nreq - n0); end
    for (int i = 0; i < N; i++) begin
      n_checks++; if (rise[i] < 0 || (i > 0 && rise[i] <= rise[i > 0 ? i - 1 : 0])) begin n_fail++; $display("FAIL rr_order client %0d: rose at %0d, previous %0d", i, rise[i], i > 0 ? rise[i-1] : -1); end
      n_checks++; if (req_log[n0 + i] !== a[i]) begin n_fail++; $display("FAIL rr_grant %0d: got %h want %h", i, req_log[n0 + i], a[i]); end
      n_checks++; if (client_dout[i*DW +: DW] !== fdata(a[i])) begin n_fail++; $display("FAIL rr_dout %0d: got %h want %h", i, client_dout[i*DW +: DW], fdata(a[i])); end
    end
  endtask

  task automatic test_addr_change();
    int n0, r0;
    bit got, seen;
    client_cs = '0;
    step();
    n0 = nreq;
    r0 = nrdy;
    client_addr[AW +: AW] = 22'h00200;
    client_cs = 4'b0010;
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (nreq > n0 && !sd.sdram_req) begin
        seen = 1;
        break;
      end
    end
    n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL chg_ack_timeout: got %b want 1", seen); end
    client_addr[AW +: AW] = 22'h00204;
    for (int c = 0; c < 30; c++) begin
      if (nrdy > r0) break;
      step();
    end
    step();
    n_checks++; if (client_ok[1] !== 1'b0) begin n_fail++; $display("FAIL chg_ok_low: got %b want 0", client_ok[1]); end
    n_checks++; if (client_dout[DW +: DW] !== fdata(22'h00200)) begin n_fail++; $display("FAIL chg_fill_data: got %h want %h", client_dout[DW +: DW], fdata(22'h00200)); end
    wait_ok(1, 40, got);
    n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL chg_ok: got %b want 1", got); end
    n_checks++; if (nreq - n0 !== 2) begin n_fail++; $display("FAIL chg_nreq: got %0d want 2", nreq - n0); end
    n_checks++; if (req_log[n0 + 1] !== 22'h00204) begin n_fail++; $display("FAIL chg_addr2: got %h want 00204", req_log[n0 + 1]); end
    n_checks++; if (client_dout[DW +: DW] !== fdata(22'h00204)) begin n_fail++; $display("FAIL chg_dout: got %h want %h", client_dout[DW +: DW], fdata(22'h00204)); end
  endtask

  task automatic test_loop_rst();
    bit got, seen;
    client_cs = '0;
    step();
    rsp_en = 0;
    client_addr[0 +: AW] = 22'h1000;
    client_addr[3*AW +: AW] = 22'h00400;
    client_cs = 4'b0001;
    #1;
    n_checks++; if (client_ok[0] !== 1'b1) begin n_fail++; $display("FAIL lr_hit_before: got %b want 1", client_ok[0]); end
    client_cs = 4'b1001;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (sd.sdram_req) begin
        seen = 1;
        break;
      end
    end
    n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL lr_req_high: got %b want 1", seen); end
    loop_rst = 1;
    client_cs = 4'b0001;
    step();
    n_checks++; if (sd.sdram_req !== 1'b0) begin n_fail++; $display("FAIL lr_req_drop: got %b want 0", sd.sdram_req); end
    n_checks++; if (client_ok !== 4'h0) begin n_fail++; $display("FAIL lr_ok_clear: got %b want 0000", client_ok); end
    loop_rst = 0;
    client_cs = '0;
    step();
    sd.data_rdy = 1;
    sd.data_read = 32'h12345678;
    step();
    sd.data_rdy = 0;
    step();
    client_cs = 4'b1000;
    #1;
    n_checks++; if (client_ok[3] !== 1'b0) begin n_fail++; $display("FAIL lr_stray_rdy: got %b want 0", client_ok[3]); end
    rsp_en = 1;
    wait_ok(3, 40, got);
    n_checks++; if (got !== 1'b1 || client_dout[3*DW +: DW] !== fdata(22'h00400)) begin n_fail++; $display("FAIL lr_recover: ok %b dout %h want 1 %h", got, client_dout[3*DW +: DW], fdata(22'h00400)); end
  endtask

  task automatic test_download();
    int n0, bad;
    bit got;
    client_cs = '0;
    step();
    client_addr[2*AW +: AW] = 22'h00300;
    client_cs = 4'b0100;
    wait_ok(2, 40, got);
    n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL dl_hit: got %b want 1", got); end
    n0 = nreq;
    downloading = 1;
    step();
    n_checks++; if (client_ok[2] !== 1'b0) begin n_fail++; $display("FAIL dl_ok_drop: got %b want 0", client_ok[2]); end
    bad = 0;
    repeat (6) begin
      step();
      if (refresh_en !== 1'b1) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL dl_refresh: got %0d low cycles want 0", bad); end
    n_checks++; if (nreq !== n0) begin n_fail++; $display("FAIL dl_no_req: got %0d want %0d", nreq, n0); end
    downloading = 0;
    wait_ok(2, 40, got);
    n_checks++; if (got !== 1'b1 || nreq - n0 !== 1) begin n_fail++; $display("FAIL dl_refetch: ok %b nreq %0d want 1 1", got, nreq - n0); end
    n_checks++; if (req_log[n0] !== 22'h00300) begin n_fail++; $display("FAIL dl_refetch_addr: got %h want 00300", req_log[n0]); end
  endtask

  task automatic test_async_reset();
    bit seen;
    client_cs = '0;
    step();
    ack_dly = 6;
    client_addr[0 +: AW] = 22'h00500;
    client_cs = 4'b0101;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (sd.sdram_req) begin
        seen = 1;
        break;
      end
    end
    n_checks++; if (seen !== 1'b1 || client_ok[2] !== 1'b1) begin n_fail++; $display("FAIL ar_setup: req %b ok2 %b want 1 1", seen, client_ok[2]); end
    rst_n = 0;
    #1;
    n_checks++; if (sd.sdram_req !== 1'b0) begin n_fail++; $display("FAIL ar_req: got %b want 0", sd.sdram_req); end
    n_checks++; if (client_ok !== 4'h0) begin n_fail++; $display("FAIL ar_ok: got %b want 0000", client_ok); end
    n_checks++; if (client_dout[2*DW +: DW] !== '0) begin n_fail++; $display("FAIL ar_dout: got %h want 0", client_dout[2*DW +: DW]); end
    client_cs = '0;
    #1;
    n_checks++; if (refresh_en !== 1'b1) begin n_fail++; $display("FAIL ar_refresh: got %b want 1", refresh_en); end
    repeat (20) step();
    rst_n = 1;
    ack_dly = 2;
    step();
    n_checks++; if (sd.sdram_req !== 1'b0) begin n_fail++; $display("FAIL ar_after: got %b want 0", sd.sdram_req); end
  endtask

  initial begin
    test_reset();
    test_single_miss();
    test_round_robin();
    test_addr_change();
    test_loop_rst();
    test_download();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
